axi_lite_ram_slave: RTL and testbench
=====================================

AXI_LITE_RAM_SLAVE -- requirements
Module: axi_lite_ram_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI data width; the strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have parameter MEM_WORDS, default 1024, RAM depth in words.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0000_0000, first byte address decoded.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have the following ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- S_AXI_AWVALID/AWREADY  in/out  1/1  write-address handshake.
- S_AXI_AWADDR  in  AXI_ADDR_WIDTH  write byte address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_WVALID/WREADY  in/out  1/1  write-data handshake.
- S_AXI_WDATA  in  AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  AXI_DATA_WIDTH/8  byte enables.
- S_AXI_BVALID/BREADY  out/in  1/1  write-response handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_ARVALID/ARREADY  in/out  1/1  read-address handshake.
- S_AXI_ARADDR  in  AXI_ADDR_WIDTH  read byte address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_RVALID/RREADY  out/in  1/1  read-data handshake.
- S_AXI_RDATA  out  AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.

Function
REQ-007 SHALL form the word index as (addr - BASE_ADDR) >> 2; addr[1:0] are ignored (no misalignment error).
REQ-008 SHALL treat an address as in range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_WORDS.
REQ-009 Write FSM SHALL have states W_IDLE, W_WAIT, W_RESP.
REQ-010 In W_IDLE and W_WAIT, AWREADY SHALL be 1 while no address is captured, and WREADY SHALL be 1 while no data is captured; AW and W are captured independently, in either order or in the same cycle.
REQ-011 When address and data are both held, the RAM write SHALL occur in that cycle, with only bytes whose WSTRB bit is 1 updated.
REQ-012 The FSM SHALL then enter W_RESP with BVALID=1 the next cycle.
- In-range write: BRESP=OKAY (2'b00).
- Out-of-range write: BRESP=SLVERR (2'b10) and no RAM change.
REQ-013 BVALID and BRESP SHALL hold until BREADY=1, then return to W_IDLE.
- AWREADY and WREADY SHALL be 0 throughout W_RESP.
- Minimum write latency (AW and W in the same cycle) SHALL be 2 cycles to BVALID.
REQ-014 Read FSM SHALL have states R_IDLE, R_DATA.
- ARREADY SHALL be 1 only in R_IDLE.
- On an AR handshake, RVALID SHALL be 1 the next cycle with RDATA = RAM word.
- Out-of-range read: RDATA=0, RRESP=SLVERR.
REQ-015 RVALID, RDATA and RRESP SHALL hold stable until RREADY=1, then return to R_IDLE; there SHALL be no back-to-back AR acceptance in the RVALID&RREADY cycle.
REQ-016 Read and write channels SHALL operate concurrently; a read and a write to the same word in the same cycle SHALL return the pre-write data.
REQ-017 WSTRB=0 SHALL complete with OKAY and no RAM change.

Reset
REQ-018 While RST=1, all of the following SHALL be 0, both FSMs SHALL be in IDLE, and captured address/data flags SHALL be cleared: AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP.
REQ-019 RAM contents SHALL NOT be cleared by reset; reset mid-transaction SHALL abort it, with no partial write if the write cycle has not yet occurred.
REQ-020 The first READY SHALL assert in the cycle after RST deasserts.

Structure
REQ-021 AXI width defaults and the OKAY/SLVERR response codes SHALL come from the shared axi_configuration package; FSM state encodings SHALL be local to the module.
REQ-022 Storage SHALL be one sub-module, byte_en_ram (1 write port with byte enables, 1 synchronous read port), to allow BRAM inference and testbench $readmemh preload.

Verification
REQ-023 Write 0x0004=0xDEADBEEF with WSTRB=1111, then read 0x0004 -> BRESP=OKAY, RDATA=0xDEADBEEF, RRESP=OKAY.
REQ-024 Then write 0x0004=0x000000AB with WSTRB=0001, then read 0x0004 -> RDATA=0xDEADBEAB.
REQ-025 Assert AWVALID (0x0008) 3 cycles before WVALID (0x12345678) -> AWREADY drops after AW capture; BVALID comes 1 cycle after the W handshake; readback = 0x12345678.
REQ-026 Write then read 0x1000 (MEM_WORDS=1024) -> BRESP=SLVERR, RRESP=SLVERR, RDATA=0, word 0 unchanged.
REQ-027 Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID, RVALID and data stay stable, and no new AW/AR is accepted.
REQ-028 Pulse RST after AW is accepted but before W -> no RAM change and all outputs 0; a following full write succeeds with OKAY.

Source files
------------

// File: rtl/axi_configuration.sv
// Shared AXI-Lite settings: default bus widths and response codes.
package axi_configuration;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_ram_slave_if.sv
// AXI4-Lite bus bundle between a master and the RAM slave.
interface axi_lite_ram_slave_if
  import axi_configuration::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
);

  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_AWREADY,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_WREADY,
    output S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_ARREADY,
    output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_AWREADY,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_WREADY,
    input  S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_ARREADY,
    input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RREADY
  );

endinterface

// File: rtl/byte_en_ram.sv
// Single-clock RAM: one byte-enabled write port, one registered
// read port with read-before-write behaviour (BRAM friendly).
module byte_en_ram #(
  parameter  int DATA_W = 32,
  parameter  int WORDS  = 1024,
  localparam int IDX_W  = $clog2(WORDS),
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [BE_W-1:0]   i_be,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [WORDS];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axi_lite_ram_slave.sv
// AXI4-Lite slave exposing a word-addressed RAM with independent
// read and write channels and SLVERR on out-of-window accesses.
module axi_lite_ram_slave
  import axi_configuration::*;
#(
  parameter int                        AXI_ADDR_WIDTH = AXI_ADDR_W,
  parameter int                        AXI_DATA_WIDTH = AXI_DATA_W,
  parameter int                        MEM_WORDS      = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input logic                 CLK,
  input logic                 RST,
  axi_lite_ram_slave_if.slave s_axi
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int SPAN_W = AXI_ADDR_WIDTH + 1;
  localparam logic [SPAN_W-1:0] SPAN = SPAN_W'(4 * MEM_WORDS);

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

  wstate_e r_wstate;
  wstate_e w_wstate_nx;
  rstate_e r_rstate;
  rstate_e w_rstate_nx;

  logic                      r_aw_have;
  logic                      r_w_have;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic [1:0]                r_bresp;
  logic                      r_rd_ok;

  logic                      w_awready;
  logic                      w_wready;
  logic                      w_bvalid;
  logic                      w_arready;
  logic                      w_rvalid;
  logic                      w_aw_hs;
  logic                      w_w_hs;
  logic                      w_ar_hs;
  logic                      w_do_wr;
  logic [AXI_ADDR_WIDTH-1:0] w_aw_off;
  logic [AXI_ADDR_WIDTH-1:0] w_ar_off;
  logic                      w_aw_ok;
  logic                      w_ar_ok;
  logic [AXI_DATA_WIDTH-1:0] w_ram_q;
  logic                      w_unused;

  // Window test on the offset; the low two address bits never matter.
  assign w_aw_off = r_awaddr - BASE_ADDR;
  assign w_ar_off = s_axi.S_AXI_ARADDR - BASE_ADDR;
  assign w_aw_ok  = (r_awaddr >= BASE_ADDR)
                 && ({1'b0, w_aw_off} < SPAN);
  assign w_ar_ok  = (s_axi.S_AXI_ARADDR >= BASE_ADDR)
                 && ({1'b0, w_ar_off} < SPAN);

  assign w_aw_hs = s_axi.S_AXI_AWVALID && w_awready;
  assign w_w_hs  = s_axi.S_AXI_WVALID && w_wready;
  assign w_ar_hs = s_axi.S_AXI_ARVALID && w_arready;

  always_comb begin
    w_wstate_nx = r_wstate;
    w_awready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    w_do_wr     = 1'b0;
    if (!RST) begin
      unique case (r_wstate)
        W_IDLE, W_WAIT: begin
          w_awready = !r_aw_have;
          w_wready  = !r_w_have;
          if (r_aw_have && r_w_have) begin
            w_do_wr     = 1'b1;
            w_wstate_nx = W_RESP;
          end else if (r_aw_have || r_w_have
                    || w_aw_hs || w_w_hs) begin
            w_wstate_nx = W_WAIT;
          end else begin
            w_wstate_nx = W_IDLE;
          end
        end
        W_RESP: begin
          w_bvalid = 1'b1;
          if (s_axi.S_AXI_BREADY) begin
            w_wstate_nx = W_IDLE;
          end
        end
        default: w_wstate_nx = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wstate  <= W_IDLE;
      r_aw_have <= 1'b0;
      r_w_have  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate <= w_wstate_nx;
      if (w_aw_hs) begin
        r_aw_have <= 1'b1;
      end
      if (w_w_hs) begin
        r_w_have <= 1'b1;
      end
      if (w_do_wr) begin
        r_aw_have <= 1'b0;
        r_w_have  <= 1'b0;
        r_bresp   <= resp_of(w_aw_ok);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_aw_hs) begin
      r_awaddr <= s_axi.S_AXI_AWADDR;
    end
    if (w_w_hs) begin
      r_wdata <= s_axi.S_AXI_WDATA;
      r_wstrb <= s_axi.S_AXI_WSTRB;
    end
  end

  always_comb begin
    w_rstate_nx = r_rstate;
    w_arready   = 1'b0;
    w_rvalid    = 1'b0;
    if (!RST) begin
      unique case (r_rstate)
        R_IDLE: begin
          w_arready = 1'b1;
          if (s_axi.S_AXI_ARVALID) begin
            w_rstate_nx = R_DATA;
          end
        end
        R_DATA: begin
          w_rvalid = 1'b1;
          if (s_axi.S_AXI_RREADY) begin
            w_rstate_nx = R_IDLE;
          end
        end
        default: w_rstate_nx = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rstate <= R_IDLE;
      r_rd_ok  <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nx;
      if (w_ar_hs) begin
        r_rd_ok <= w_ar_ok;
      end
    end
  end

  byte_en_ram #(
    .DATA_W (AXI_DATA_WIDTH),
    .WORDS  (MEM_WORDS)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_do_wr && w_aw_ok),
    .i_waddr (w_aw_off[IDX_W+1:2]),
    .i_be    (r_wstrb),
    .i_wdata (r_wdata),
    .i_re    (w_ar_hs),
    .i_raddr (w_ar_off[IDX_W+1:2]),
    .o_rdata (w_ram_q)
  );

  assign s_axi.S_AXI_AWREADY = w_awready;
  assign s_axi.S_AXI_WREADY  = w_wready;
  assign s_axi.S_AXI_BVALID  = w_bvalid;
  assign s_axi.S_AXI_BRESP   = w_bvalid ? r_bresp : RESP_OKAY;
  assign s_axi.S_AXI_ARREADY = w_arready;
  assign s_axi.S_AXI_RVALID  = w_rvalid;
  assign s_axi.S_AXI_RDATA   = (w_rvalid && r_rd_ok) ? w_ram_q : '0;
  assign s_axi.S_AXI_RRESP   = w_rvalid ? resp_of(r_rd_ok)
                                        : RESP_OKAY;

  assign w_unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Randomized bench for axi_lite_ram_slave against a word-array
// model of the memory and its response rules.
module tb_axi_lite_ram_slave;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WORDS = 1024;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  always #5 CLK = ~CLK;

  axi_lite_ram_slave_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_ram_slave #(
    .AXI_ADDR_WIDTH (AW),
    .AXI_DATA_WIDTH (DW),
    .MEM_WORDS      (WORDS),
    .BASE_ADDR      (32'h0000_0000)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .s_axi (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ref_mem [int];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return a < 32'(4 * WORDS);
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_win(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a,
                                      input logic [31:0] d,
                                      input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (!in_win(a)) return;
    if (ref_mem.exists(idx)) ref_mem[idx] = merge(ref_mem[idx], d, s);
    else if (s == 4'hF) ref_mem[idx] = d;
  endfunction

  function automatic logic [31:0] outs_vec();
    return {20'd0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
            bus.S_AXI_BVALID, bus.S_AXI_BRESP, bus.S_AXI_ARREADY,
            bus.S_AXI_RVALID, bus.S_AXI_RRESP, 3'd0}
           | bus.S_AXI_RDATA;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int aw_at,
                          input int w_at, input int bdly,
                          output int lat);
    int n;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [1:0] resp;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = (aw_at == 0);
    bus.S_AXI_WVALID  = (w_at == 0);
    aw_done = 0;
    w_done  = 0;
    n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      n++;
      if (aw_hs) begin aw_done = 1; bus.S_AXI_AWVALID = 0; end
      if (w_hs) begin w_done = 1; bus.S_AXI_WVALID = 0; end
      if (!aw_done && n >= aw_at) bus.S_AXI_AWVALID = 1;
      if (!w_done && n >= w_at) bus.S_AXI_WVALID = 1;
    end
    bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WVALID  = 0;
    lat = 0;
    while (!bus.S_AXI_BVALID && lat < 40) begin
      tick();
      lat++;
    end
    chk("bvalid", bus.S_AXI_BVALID, 1);
    repeat (bdly) begin
      tick();
      chk("b_hold", {bus.S_AXI_BVALID, bus.S_AXI_BRESP},
          {1'b1, exp_resp(a)});
    end
    resp = bus.S_AXI_BRESP;
    bus.S_AXI_BREADY = 1;
    tick();
    bus.S_AXI_BREADY = 0;
    chk("bresp", resp, exp_resp(a));
    model_write(a, d, s);
  endtask

  task automatic check_read(input logic [31:0] a, input int rdly);
    int n;
    int idx;
    logic [31:0] first;
    logic [31:0] data;
    logic [1:0]  resp;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 40) begin
      tick();
      n++;
    end
    tick();
    bus.S_AXI_ARVALID = 0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 40) begin
      tick();
      n++;
    end
    chk("rvalid", bus.S_AXI_RVALID, 1);
    first = bus.S_AXI_RDATA;
    repeat (rdly) begin
      tick();
      chk("r_hold", bus.S_AXI_RDATA, first);
    end
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    bus.S_AXI_RREADY = 1;
    tick();
    bus.S_AXI_RREADY = 0;
    chk("rresp", resp, exp_resp(a));
    idx = int'(a >> 2);
    if (!in_win(a)) chk("rdata_oor", data, 32'h0);
    else if (ref_mem.exists(idx)) chk("rdata", data, ref_mem[idx]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] a, d, old;
    bus.S_AXI_AWVALID = 0; bus.S_AXI_AWADDR = '0;
    bus.S_AXI_AWPROT  = '0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_WDATA   = '0; bus.S_AXI_WSTRB = '0;
    bus.S_AXI_BREADY  = 0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_ARADDR  = '0; bus.S_AXI_ARPROT = '0;
    bus.S_AXI_RREADY  = 0;

    RST = 1;
    repeat (3) tick();
    chk("reset_outs", outs_vec(), 32'h0);
    RST = 0;
    tick();
    chk("ready_after_rst",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY},
        3'b111);

    for (int i = 0; i < 16; i++) begin
      do_write(32'(i * 4), $urandom, 4'hF, 0, 0, 0, lat);
    end

    do_write(32'h4, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, lat);
    chk("wr_latency", lat, 1);
    check_read(32'h4, 0);
    do_write(32'h4, 32'h0000_00AB, 4'h1, 0, 0, 0, lat);
    check_read(32'h4, 0);
    chk("strb_merge", ref_mem[1], 32'hDEAD_BEAB);

    bus.S_AXI_AWADDR  = 32'h8;
    bus.S_AXI_AWVALID = 1;
    chk("aw_ready_pre", bus.S_AXI_AWREADY, 1);
    tick();
    bus.S_AXI_AWVALID = 0;
    chk("aw_ready_drop", bus.S_AXI_AWREADY, 0);
    tick();
    tick();
    bus.S_AXI_WDATA  = 32'h1234_5678;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_WVALID = 1;
    chk("w_ready", bus.S_AXI_WREADY, 1);
    tick();
    bus.S_AXI_WVALID = 0;
    chk("bvalid_early", bus.S_AXI_BVALID, 0);
    tick();
    chk("bvalid_late", {bus.S_AXI_BVALID, bus.S_AXI_BRESP}, 3'b100);
    bus.S_AXI_BREADY = 1;
    tick();
    bus.S_AXI_BREADY = 0;
    model_write(32'h8, 32'h1234_5678, 4'hF);
    check_read(32'h8, 0);

    do_write(32'h1000, 32'hCAFE_F00D, 4'hF, 0, 0, 1, lat);
    check_read(32'h1000, 1);
    check_read(32'h0, 0);

    do_write(32'h10, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, lat);
    check_read(32'h10, 0);

    old = ref_mem[3];
    bus.S_AXI_AWADDR = 32'hC; bus.S_AXI_WDATA = 32'h5A5A_1234;
    bus.S_AXI_WSTRB  = 4'hF;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
    bus.S_AXI_ARADDR = 32'hC;
    tick();
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_ARVALID = 1;
    tick();
    bus.S_AXI_ARVALID = 0;
    chk("rd_wr_same_word", bus.S_AXI_RDATA, old);
    chk("rd_wr_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    tick();
    bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
    model_write(32'hC, 32'h5A5A_1234, 4'hF);
    check_read(32'hC, 0);

    bus.S_AXI_AWADDR = 32'h14; bus.S_AXI_WDATA = 32'h0BAD_CAFE;
    bus.S_AXI_WSTRB  = 4'hF; bus.S_AXI_ARADDR = 32'h18;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
    bus.S_AXI_ARVALID = 1;
    tick();
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_ARVALID = 0;
    tick();
    bus.S_AXI_AWADDR = 32'h40; bus.S_AXI_ARADDR = 32'h40;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_ARVALID = 1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID,
          bus.S_AXI_BRESP, bus.S_AXI_RRESP}, 6'b110000);
      chk("hold_rdata", bus.S_AXI_RDATA, ref_mem[6]);
      chk("hold_no_accept", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY},
          2'b00);
      tick();
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    tick();
    bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
    model_write(32'h14, 32'h0BAD_CAFE, 4'hF);
    chk("idle_again", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY,
        bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 4'b1100);
    check_read(32'h14, 0);

    bus.S_AXI_AWADDR = 32'h20; bus.S_AXI_AWVALID = 1;
    tick();
    bus.S_AXI_AWVALID = 0;
    RST = 1;
    bus.S_AXI_WDATA = 32'hFFFF_FFFF; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_WVALID = 1;
    tick();
    chk("mid_rst_outs", outs_vec(), 32'h0);
    tick();
    RST = 0;
    bus.S_AXI_WVALID = 0;
    tick();
    check_read(32'h20, 0);
    do_write(32'h24, 32'h7777_1111, 4'hF, 0, 0, 0, lat);
    check_read(32'h20, 0);
    check_read(32'h24, 0);

    for (int i = 0; i < 60; i++) begin
      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 0)
            ? 32'h1000 + 32'($urandom_range(0, 1023) * 4)
            : 32'hFFFF_FFFC;
      end
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, d, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), lat);
      end else begin
        check_read(a, $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
